regfile_scoreboard: RTL and testbench

Parametrised integer register file for the RV32IM core with N combinational read ports, one write port, x0 hardwired to zero, optional write-to-read bypass and a per-register busy scoreboard. The scoreboard tracks long-latency producers such as loads and the multicycle divider so that decode can stall on RAW/WAW hazards. Sits between decode (reads, reservations) and writeback (writes, busy release).

---
 rtl/regfile_scoreboard.sv | 112 +++++++++++
 tb/tb_regfile_scoreboard.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: integer register file with NREAD combinational read
// ports, one write port, x0 hardwired to zero, optional write-to-read bypass
// and a per-register busy scoreboard for long-latency producers.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   rs_addr      : NREAD packed read addresses (port k at [k*AW +: AW])
//   rs_data      : NREAD packed read data (port k at [k*XLEN +: XLEN])
//   rs_busy      : per read port, source register has a pending producer
//   wr_en/addr/data : writeback port; every write also releases busy[wr_addr]
//   resv_valid/addr : decode request to mark a destination busy
//   resv_ready   : reservation can be accepted this cycle
//   flush        : clear all busy bits, drop this cycle's reservation
//   pending_cnt  : registered count of busy registers
module regfile_scoreboard #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned AW     = $clog2(NREGS),
    parameter int unsigned NREAD  = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREAD*AW-1:0]          rs_addr,
    output logic [NREAD*XLEN-1:0]        rs_data,
    output logic [NREAD-1:0]             rs_busy,
    input  logic                         wr_en,
    input  logic [AW-1:0]                wr_addr,
    input  logic [XLEN-1:0]              wr_data,
    input  logic                         resv_valid,
    input  logic [AW-1:0]                resv_addr,
    output logic                         resv_ready,
    input  logic                         flush,
    output logic [$clog2(NREGS+1)-1:0]   pending_cnt
);

    localparam int unsigned CW = $clog2(NREGS + 1);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;
    logic [CW-1:0]    cnt_next;
    logic [AW-1:0]    rd_addr [NREAD];
    logic             rd_hit  [NREAD];
    logic             resv_take;

    // Read ports: x0 forced to zero, same-cycle write releases busy and
    // optionally forwards its data.
    always_comb begin
        rs_data = '0;
        rs_busy = '0;
        for (int unsigned k = 0; k < NREAD; k++) begin
            rd_addr[k] = rs_addr[k*AW +: AW];
            rd_hit[k]  = wr_en && (wr_addr == rd_addr[k]);
            if (rd_addr[k] != '0) begin
                if ((BYPASS != 0) && rd_hit[k]) begin
                    rs_data[k*XLEN +: XLEN] = wr_data;
                end else begin
                    rs_data[k*XLEN +: XLEN] = regs[rd_addr[k]];
                end
                rs_busy[k] = busy[rd_addr[k]] & ~rd_hit[k];
            end
        end
    end

    // Reservation admission: blocks WAW while the old producer is outstanding,
    // unless that producer writes back this very cycle.
    always_comb begin
        resv_ready = ~flush & ~rst &
                     ((resv_addr == '0) | ~busy[resv_addr] |
                      (wr_en && (wr_addr == resv_addr)));
        resv_take  = resv_valid & resv_ready & (resv_addr != '0);
    end

    // Next busy vector: release on write, set on reservation (set wins),
    // flush clears everything; count follows the new vector.
    always_comb begin
        busy_next = busy;
        if (wr_en) begin
            busy_next[wr_addr] = 1'b0;
        end
        if (resv_take) begin
            busy_next[resv_addr] = 1'b1;
        end
        if (flush) begin
            busy_next = '0;
        end
        busy_next[0] = 1'b0;
        cnt_next = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            cnt_next = cnt_next + CW'(busy_next[i]);
        end
    end

    // State update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            busy        <= '0;
            pending_cnt <= '0;
        end else begin
            if (wr_en && (wr_addr != '0)) begin
                regs[wr_addr] <= wr_data;
            end
            busy        <= busy_next;
            pending_cnt <= cnt_next;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: one BYPASS=1 instance and one
// BYPASS=0 instance share all inputs; expected values are hand-computed.
module tb_regfile_scoreboard;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned NREAD = 2;
    localparam int unsigned CW    = 6;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NREAD*AW-1:0]     rs_addr;
    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic [XLEN-1:0]         wr_data;
    logic                    resv_valid;
    logic [AW-1:0]           resv_addr;
    logic                    flush;

    logic [NREAD*XLEN-1:0]   rs_data,  nb_rs_data;
    logic [NREAD-1:0]        rs_busy,  nb_rs_busy;
    logic                    resv_ready, nb_resv_ready;
    logic [CW-1:0]           pending_cnt, nb_pending_cnt;

    int compared   = 0;
    int mismatched = 0;

    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NREAD(NREAD), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .resv_valid(resv_valid), .resv_addr(resv_addr), .resv_ready(resv_ready),
        .flush(flush), .pending_cnt(pending_cnt)
    );

    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NREAD(NREAD), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(nb_rs_data), .rs_busy(nb_rs_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .resv_valid(resv_valid), .resv_addr(resv_addr), .resv_ready(nb_resv_ready),
        .flush(flush), .pending_cnt(nb_pending_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rs_addr = {a1, a0};
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        resv_valid = 1'b0; resv_addr = '0; flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        rs_addr = '0;
        step();

        // Reset: write and reservation ignored, ready held low
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h0000_FFFF;
        resv_valid = 1'b1; resv_addr = 5'd6;
        #1;
        check("ready_in_reset", 32'(resv_ready), 32'd0);
        step();
        rst = 1'b0;
        idle();
        set_rd(5'd5, 5'd31);
        check("rst_data0", rs_data[31:0], 32'd0);
        check("rst_data1", rs_data[63:32], 32'd0);
        check("rst_busy", 32'(rs_busy), 32'd0);
        check("rst_pending", 32'(pending_cnt), 32'd0);
        set_rd(5'd6, 5'd6);
        check("rst_write_ignored", rs_data[31:0], 32'd0);
        check("rst_resv_ignored", 32'(rs_busy), 32'd0);

        // Write with same-cycle read: bypass vs stored value
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEAD_BEEF;
        set_rd(5'd3, 5'd4);
        check("bypass_data", rs_data[31:0], 32'hDEAD_BEEF);
        check("nobypass_old", nb_rs_data[31:0], 32'd0);
        check("bypass_other_port", rs_data[63:32], 32'd0);
        step();
        idle();
        set_rd(5'd3, 5'd3);
        check("stored_bypass", rs_data[31:0], 32'hDEAD_BEEF);
        check("stored_nobypass", nb_rs_data[31:0], 32'hDEAD_BEEF);
        check("same_addr_ports", rs_data[63:32], 32'hDEAD_BEEF);

        // x0 protection
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h0000_1234;
        resv_valid = 1'b1; resv_addr = 5'd0;
        set_rd(5'd0, 5'd0);
        check("x0_bypass_zero", rs_data[31:0], 32'd0);
        check("x0_ready", 32'(resv_ready), 32'd1);
        check("x0_busy", 32'(rs_busy), 32'd0);
        step();
        idle();
        set_rd(5'd0, 5'd0);
        check("x0_stored_zero", rs_data[31:0], 32'd0);
        check("x0_busy_after", 32'(rs_busy), 32'd0);
        check("x0_pending", 32'(pending_cnt), 32'd0);

        // Scoreboard: reserve x7, block WAW, release on writeback
        resv_valid = 1'b1; resv_addr = 5'd7;
        #1;
        check("x7_ready_first", 32'(resv_ready), 32'd1);
        step();
        set_rd(5'd7, 5'd7);
        check("x7_busy", 32'(rs_busy), 32'd3);
        check("x7_pending", 32'(pending_cnt), 32'd1);
        check("x7_waw_block", 32'(resv_ready), 32'd0);
        resv_valid = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_0055;
        #1;
        check("x7_wb_busy_clear", 32'(rs_busy), 32'd0);
        check("x7_wb_busy_clear_nb", 32'(nb_rs_busy), 32'd0);
        check("x7_wb_data", rs_data[31:0], 32'h0000_0055);
        check("x7_wb_ready", 32'(resv_ready), 32'd1);
        step();
        idle();
        #1;
        check("x7_pending_after", 32'(pending_cnt), 32'd0);
        check("x7_stored", rs_data[31:0], 32'h0000_0055);

        // Simultaneous set/clear on x9: set wins
        resv_valid = 1'b1; resv_addr = 5'd9;
        step();
        idle();
        set_rd(5'd9, 5'd0);
        check("x9_pending_1", 32'(pending_cnt), 32'd1);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_0099;
        resv_valid = 1'b1; resv_addr = 5'd9;
        #1;
        check("x9_ready_with_wb", 32'(resv_ready), 32'd1);
        step();
        idle();
        #1;
        check("x9_still_busy", 32'(rs_busy), 32'd1);
        check("x9_data", rs_data[31:0], 32'h0000_0099);
        check("x9_pending_keep", 32'(pending_cnt), 32'd1);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_0099;
        step();
        idle();
        #1;
        check("x9_released", 32'(pending_cnt), 32'd0);

        // Flush mid-operation
        for (int r = 1; r <= 3; r++) begin
            resv_valid = 1'b1; resv_addr = AW'(r);
            step();
            idle();
            #1;
            check($sformatf("flush_pre_cnt%0d", r), 32'(pending_cnt), 32'(r));
        end
        check("flush_pre_cnt_nb", 32'(nb_pending_cnt), 32'd3);
        flush = 1'b1;
        resv_valid = 1'b1; resv_addr = 5'd4;
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h0000_000A;
        set_rd(5'd2, 5'd3);
        check("flush_ready_low", 32'(resv_ready), 32'd0);
        check("flush_busy_before", 32'(rs_busy), 32'd3);
        step();
        idle();
        set_rd(5'd1, 5'd4);
        check("flush_busy_x1_x4", 32'(rs_busy), 32'd0);
        check("flush_pending", 32'(pending_cnt), 32'd0);
        set_rd(5'd10, 5'd3);
        check("flush_wr_kept", rs_data[31:0], 32'h0000_000A);
        check("flush_busy_x3", 32'(rs_busy), 32'd0);
        check("flush_ready_after", 32'(resv_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
